// File: rtl/trace_mem_arbiter.sv
// trace_mem_arbiter
// Sequences the single-port trace memory between the tracer store path, the
// tracer load path and a host dump port. Owns the write/read pointers, the
// stream-mode fill count and the post-trigger delay countdown.
//
// Ports:
//   FPGA_CLK_I, RST_I          clock, synchronous active-high reset
//   MODE_I                     0 = trace (circular buffer), 1 = stream (FIFO)
//   TRG_EVENT_I, TRG_DELAY_I   sticky trigger and words to store after it
//   TRG_DELAYED_O              sticky: post-trigger delay has expired
//   STORE_I, DATA_I            store pulse and its data
//   STORE_PERM_O               the next STORE_I will be accepted
//   LOAD_REQUEST_I             load request pulse
//   LOAD_GRANT_O, DATA_O       one-cycle grant with the loaded word
//   HOST_REQ_I, HOST_ADDR_I    host dump request, index from the oldest word
//   HOST_ACK_O, HOST_DATA_O    one-cycle ack with the dump word
//   MEM_ADDR_O, MEM_WE_O,
//   MEM_WDATA_O, MEM_RDATA_I   single-port memory, read data 1 cycle late
module trace_mem_arbiter #(
  parameter int TRB_WIDTH      = 32,
  parameter int TRB_DEPTH      = 16,
  parameter int TRB_DELAY_BITS = 16,
  localparam int AW            = $clog2(TRB_DEPTH)
) (
  input  logic                      FPGA_CLK_I,
  input  logic                      RST_I,
  input  logic                      MODE_I,
  input  logic                      TRG_EVENT_I,
  input  logic [TRB_DELAY_BITS-1:0] TRG_DELAY_I,
  output logic                      TRG_DELAYED_O,
  input  logic                      STORE_I,
  input  logic [TRB_WIDTH-1:0]      DATA_I,
  output logic                      STORE_PERM_O,
  input  logic                      LOAD_REQUEST_I,
  output logic                      LOAD_GRANT_O,
  output logic [TRB_WIDTH-1:0]      DATA_O,
  input  logic                      HOST_REQ_I,
  input  logic [AW-1:0]             HOST_ADDR_I,
  output logic                      HOST_ACK_O,
  output logic [TRB_WIDTH-1:0]      HOST_DATA_O,
  output logic [AW-1:0]             MEM_ADDR_O,
  output logic                      MEM_WE_O,
  output logic [TRB_WIDTH-1:0]      MEM_WDATA_O,
  input  logic [TRB_WIDTH-1:0]      MEM_RDATA_I
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARMED     = 3'd1;
  localparam logic [2:0] ST_TRIGGERED = 3'd2;
  localparam logic [2:0] ST_DONE      = 3'd3;
  localparam logic [2:0] ST_STREAM    = 3'd4;

  // count needs one extra bit so that a full buffer (== TRB_DEPTH) is representable
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TRB_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [TRB_DELAY_BITS-1:0] DLY_ONE = TRB_DELAY_BITS'(1);

  logic [2:0]                state_q, state_d;
  logic                      mode_q;
  logic [AW-1:0]             wptr_q, wptr_d;
  logic [AW-1:0]             rptr_q, rptr_d;
  logic [AW:0]               count_q, count_d;
  logic [TRB_DELAY_BITS-1:0] delay_q, delay_d;
  logic                      delayed_q, delayed_d;
  logic                      st_pend_q, st_pend_d;
  logic [TRB_WIDTH-1:0]      st_data_q, st_data_d;
  logic                      ld_pend_q, ld_pend_d;
  logic                      host_pend_q, host_pend_d;
  logic [AW-1:0]             host_addr_q, host_addr_d;
  logic                      ld_rd_q, host_rd_q;

  logic store_perm;
  logic store_accept;
  logic wr_issue;
  logic load_ok;
  logic ld_issue;
  logic host_issue;
  logic mode_change;

  assign mode_change = (MODE_I != mode_q);

  always_comb begin
    store_perm = 1'b1;
    if (state_q == ST_DONE) begin
      store_perm = 1'b0;
    end else if (mode_q) begin
      // A latched-but-unwritten store already owns a slot.
      store_perm = ((count_q + {{AW{1'b0}}, st_pend_q}) < DEPTH_C);
    end
  end

  assign store_accept = STORE_I && store_perm;

  // Fixed priority: the pending store always wins, so it never waits more
  // than one cycle; loads in stream mode need data, in trace mode any state
  // but DONE; host reads only once the capture is finished.
  assign wr_issue   = st_pend_q;
  assign load_ok    = mode_q ? (count_q != '0) : (state_q != ST_DONE);
  assign ld_issue   = ld_pend_q && !st_pend_q && load_ok;
  assign host_issue = host_pend_q && !st_pend_q && !ld_issue && (state_q == ST_DONE);

  always_comb begin
    MEM_WE_O    = wr_issue;
    MEM_WDATA_O = wr_issue ? st_data_q : '0;
    MEM_ADDR_O  = '0;
    if (wr_issue) begin
      MEM_ADDR_O = wptr_q;
    end else if (ld_issue) begin
      // Trace mode reads at wptr: the oldest word, i.e. a full-depth delay line.
      MEM_ADDR_O = mode_q ? rptr_q : wptr_q;
    end else if (host_issue) begin
      MEM_ADDR_O = wptr_q + host_addr_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    delay_d     = delay_q;
    delayed_d   = delayed_q;
    st_pend_d   = st_pend_q;
    st_data_d   = st_data_q;
    host_pend_d = host_pend_q;
    host_addr_d = host_addr_q;

    if (wr_issue) begin
      wptr_d    = wptr_q + 1'b1;
      st_pend_d = 1'b0;
    end
    // The pending slot frees at the same edge it is written, so a new store
    // can be taken back to back.
    if (store_accept) begin
      st_pend_d = 1'b1;
      st_data_d = DATA_I;
    end

    ld_pend_d = ld_issue ? 1'b0 : (ld_pend_q | LOAD_REQUEST_I);

    if (ld_issue && mode_q) begin
      rptr_d = rptr_q + 1'b1;
    end

    if (mode_q) begin
      case ({wr_issue, ld_issue})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    if (host_issue) begin
      host_pend_d = 1'b0;
    end else if (!host_pend_q && HOST_REQ_I) begin
      host_pend_d = 1'b1;
      host_addr_d = HOST_ADDR_I;
    end

    case (state_q)
      ST_IDLE: state_d = mode_q ? ST_STREAM : ST_ARMED;
      ST_ARMED: begin
        if (TRG_EVENT_I) begin
          state_d = ST_TRIGGERED;
          delay_d = TRG_DELAY_I;
        end
      end
      ST_TRIGGERED: begin
        if (delay_q == '0) begin
          state_d   = ST_DONE;
          delayed_d = 1'b1;
        end else if (store_accept) begin
          delay_d = delay_q - DLY_ONE;
        end
      end
      ST_DONE:   state_d = ST_DONE;
      ST_STREAM: state_d = ST_STREAM;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I || mode_change) begin
      // A mode change flushes like reset but keeps the sticky delayed flag.
      // Any read in flight is dropped silently.
      state_q     <= ST_IDLE;
      mode_q      <= MODE_I;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      delay_q     <= '0;
      delayed_q   <= RST_I ? 1'b0 : delayed_q;
      st_pend_q   <= 1'b0;
      st_data_q   <= '0;
      ld_pend_q   <= 1'b0;
      host_pend_q <= 1'b0;
      host_addr_q <= '0;
      ld_rd_q     <= 1'b0;
      host_rd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_q;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      delay_q     <= delay_d;
      delayed_q   <= delayed_d;
      st_pend_q   <= st_pend_d;
      st_data_q   <= st_data_d;
      ld_pend_q   <= ld_pend_d;
      host_pend_q <= host_pend_d;
      host_addr_q <= host_addr_d;
      ld_rd_q     <= ld_issue;
      host_rd_q   <= host_issue;
    end
  end

  assign TRG_DELAYED_O = delayed_q;
  assign STORE_PERM_O  = store_perm;
  assign LOAD_GRANT_O  = ld_rd_q;
  assign DATA_O        = ld_rd_q ? MEM_RDATA_I : '0;
  assign HOST_ACK_O    = host_rd_q;
  assign HOST_DATA_O   = host_rd_q ? MEM_RDATA_I : '0;

endmodule

// File: tb/tb_trace_mem_arbiter.sv
// Directed testbench for trace_mem_arbiter with a simple 1-cycle-latency
// memory model. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_trace_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        trg;
  logic [15:0] trg_delay;
  logic        delayed;
  logic        store;
  logic [31:0] data_in;
  logic        perm;
  logic        ld;
  logic        grant;
  logic [31:0] data_out;
  logic        hreq;
  logic [3:0]  haddr;
  logic        hack;
  logic [31:0] hdata;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:15];

  int n_cmp = 0;
  int n_bad = 0;

  trace_mem_arbiter #(.TRB_WIDTH(32), .TRB_DEPTH(16), .TRB_DELAY_BITS(16)) dut (
    .FPGA_CLK_I    (clk),
    .RST_I         (rst),
    .MODE_I        (mode),
    .TRG_EVENT_I   (trg),
    .TRG_DELAY_I   (trg_delay),
    .TRG_DELAYED_O (delayed),
    .STORE_I       (store),
    .DATA_I        (data_in),
    .STORE_PERM_O  (perm),
    .LOAD_REQUEST_I(ld),
    .LOAD_GRANT_O  (grant),
    .DATA_O        (data_out),
    .HOST_REQ_I    (hreq),
    .HOST_ADDR_I   (haddr),
    .HOST_ACK_O    (hack),
    .HOST_DATA_O   (hdata),
    .MEM_ADDR_O    (mem_addr),
    .MEM_WE_O      (mem_we),
    .MEM_WDATA_O   (mem_wdata),
    .MEM_RDATA_I   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    rst = 1'b1; mode = m; trg = 1'b0; trg_delay = '0; store = 1'b0; data_in = '0;
    ld = 1'b0; hreq = 1'b0; haddr = '0;
    step(); step();
    rst = 1'b0;
    step(); step();
  endtask

  task automatic pulse_store(input logic [31:0] d);
    data_in = d; store = 1'b1;
    step();
    store = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; trg = 1'b0; trg_delay = '0; store = 1'b0; data_in = '0;
    ld = 1'b0; hreq = 1'b0; haddr = '0;
    step(); step();
    n_cmp++; if (perm !== 1'b1) begin n_bad++; $display("FAIL reset_perm: got %0b want 1", perm); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %0b want 0", mem_we); end
    n_cmp++; if (grant !== 1'b0) begin n_bad++; $display("FAIL reset_grant: got %0b want 0", grant); end
    n_cmp++; if (hack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %0b want 0", hack); end
    n_cmp++; if (delayed !== 1'b0) begin n_bad++; $display("FAIL reset_delayed: got %0b want 0", delayed); end
    n_cmp++; if (mem_addr !== 4'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
    rst = 1'b0;
    step(); step();
    $display("test_reset done");
  endtask

  task automatic test_trace_delay();
    do_reset(1'b0);
    trg_delay = 16'd3;
    for (int i = 1; i <= 10; i++) begin
      n_cmp++; if (perm !== 1'(i <= 8)) begin n_bad++; $display("FAIL perm_before_store%0d: got %0b want %0b", i, perm, (i <= 8)); end
      pulse_store(32'(i));
      n_cmp++; if (mem_we !== 1'(i <= 8)) begin n_bad++; $display("FAIL store_we%0d: got %0b want %0b", i, mem_we, (i <= 8)); end
      if (i <= 8) begin
        n_cmp++; if (mem_addr !== 4'(i - 1)) begin n_bad++; $display("FAIL store_addr%0d: got %0d want %0d", i, mem_addr, i - 1); end
      end
      if (i == 5) trg = 1'b1;
      step(); step();
      n_cmp++; if (delayed !== 1'(i >= 8)) begin n_bad++; $display("FAIL trg_delayed%0d: got %0b want %0b", i, delayed, (i >= 8)); end
      $display("trace store %0d perm=%0b delayed=%0b", i, perm, delayed);
    end
    // loads are never granted in DONE
    ld = 1'b1; step(); ld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (grant !== 1'b0) begin n_bad++; $display("FAIL done_load_grant: got %0b want 0", grant); end
      step();
    end
    // mode change keeps the sticky flag
    mode = 1'b1; step(); step();
    n_cmp++; if (delayed !== 1'b1) begin n_bad++; $display("FAIL delayed_sticky: got %0b want 1", delayed); end
    n_cmp++; if (perm !== 1'b1) begin n_bad++; $display("FAIL perm_after_flush: got %0b want 1", perm); end
    trg = 1'b0;
  endtask

  task automatic test_host_dump();
    logic        got;
    logic [31:0] hd;
    logic [3:0]  addrs [2];
    logic [31:0] exps  [2];
    addrs[0] = 4'd0;  exps[0] = 32'd4;
    addrs[1] = 4'd15; exps[1] = 32'd19;
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      pulse_store(32'(i));
      step();
    end
    // trace-mode load returns the oldest word
    ld = 1'b1; step(); ld = 1'b0;
    n_cmp++; if (grant !== 1'b0) begin n_bad++; $display("FAIL trace_load_early: got %0b want 0", grant); end
    step();
    n_cmp++; if (grant !== 1'b1) begin n_bad++; $display("FAIL trace_load_grant: got %0b want 1", grant); end
    n_cmp++; if (data_out !== 32'd4) begin n_bad++; $display("FAIL trace_load_data: got %0d want 4", data_out); end
    // host request before DONE is held
    haddr = 4'd0; hreq = 1'b1; step(); hreq = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (hack !== 1'b0) begin n_bad++; $display("FAIL host_early_ack: got %0b want 0", hack); end
      step();
    end
    trg_delay = 16'd0; trg = 1'b1;
    got = 1'b0; hd = '0;
    for (int k = 0; k < 6 && !got; k++) begin
      step();
      if (hack) begin got = 1'b1; hd = hdata; end
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL host_held_ack: got %0b want 1 (timeout)", got); end
    n_cmp++; if (hd !== 32'd4) begin n_bad++; $display("FAIL host_held_data: got %0d want 4", hd); end
    n_cmp++; if (delayed !== 1'b1) begin n_bad++; $display("FAIL delay0_done: got %0b want 1", delayed); end
    step();
    for (int j = 0; j < 2; j++) begin
      haddr = addrs[j]; hreq = 1'b1; step(); hreq = 1'b0;
      n_cmp++; if (hack !== 1'b0) begin n_bad++; $display("FAIL host_ack_early%0d: got %0b want 0", j, hack); end
      step();
      n_cmp++; if (hack !== 1'b1) begin n_bad++; $display("FAIL host_ack%0d: got %0b want 1", j, hack); end
      n_cmp++; if (hdata !== exps[j]) begin n_bad++; $display("FAIL host_data%0d: got %0d want %0d", j, hdata, exps[j]); end
      $display("host addr %0d -> %0d", addrs[j], hdata);
      step();
      n_cmp++; if (hack !== 1'b0) begin n_bad++; $display("FAIL host_ack_pulse%0d: got %0b want 0", j, hack); end
    end
    trg = 1'b0;
  endtask

  task automatic test_stream_full_empty();
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) begin
      pulse_store(32'(100 + i));
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 4'(i)) begin n_bad++; $display("FAIL stream_write%0d: got we=%0b addr=%0d want we=1 addr=%0d", i, mem_we, mem_addr, i); end
      step();
    end
    n_cmp++; if (perm !== 1'b0) begin n_bad++; $display("FAIL stream_full_perm: got %0b want 0", perm); end
    pulse_store(32'd999);
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL stream_full_drop: got %0b want 0", mem_we); end
    for (int i = 0; i < 16; i++) begin
      ld = 1'b1; step(); ld = 1'b0; step();
      n_cmp++; if (grant !== 1'b1) begin n_bad++; $display("FAIL stream_grant%0d: got %0b want 1", i, grant); end
      n_cmp++; if (data_out !== 32'(100 + i)) begin n_bad++; $display("FAIL stream_data%0d: got %0d want %0d", i, data_out, 100 + i); end
      if (i == 0) begin
        n_cmp++; if (perm !== 1'b1) begin n_bad++; $display("FAIL stream_perm_back: got %0b want 1", perm); end
      end
    end
    $display("stream drained 16 words");
    for (int i = 0; i < 16; i++) begin
      ld = 1'b1; step(); ld = 1'b0; step();
      n_cmp++; if (grant !== 1'b0) begin n_bad++; $display("FAIL empty_grant%0d: got %0b want 0", i, grant); end
    end
  endtask

  task automatic test_contention();
    do_reset(1'b1);
    pulse_store(32'hAA); step(); step();
    data_in = 32'hBB; store = 1'b1; ld = 1'b1;
    step();
    store = 1'b0; ld = 1'b0;
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 4'd1 || mem_wdata !== 32'hBB) begin n_bad++; $display("FAIL cont_write_first: got we=%0b addr=%0d wd=%0h want 1/1/bb", mem_we, mem_addr, mem_wdata); end
    step();
    n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 4'd0 || grant !== 1'b0) begin n_bad++; $display("FAIL cont_read_issue: got we=%0b addr=%0d grant=%0b want 0/0/0", mem_we, mem_addr, grant); end
    step();
    n_cmp++; if (grant !== 1'b1) begin n_bad++; $display("FAIL cont_grant: got %0b want 1", grant); end
    n_cmp++; if (data_out !== 32'hAA) begin n_bad++; $display("FAIL cont_data: got %0h want aa", data_out); end
    $display("contention grant data=%0h", data_out);
    step();
    ld = 1'b1; step(); ld = 1'b0; step();
    n_cmp++; if (grant !== 1'b1 || data_out !== 32'hBB) begin n_bad++; $display("FAIL cont_second: got grant=%0b data=%0h want 1/bb", grant, data_out); end
    ld = 1'b1; step(); ld = 1'b0; step();
    n_cmp++; if (grant !== 1'b0) begin n_bad++; $display("FAIL cont_empty: got %0b want 0", grant); end
  endtask

  task automatic test_flush();
    do_reset(1'b1);
    for (int i = 1; i <= 5; i++) begin
      pulse_store(32'(i)); step();
    end
    data_in = 32'h77; store = 1'b1; ld = 1'b1;
    step();
    store = 1'b0; ld = 1'b0;
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 4'd5) begin n_bad++; $display("FAIL flush_pre_write: got we=%0b addr=%0d want 1/5", mem_we, mem_addr); end
    mode = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (grant !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL flush_quiet%0d: got grant=%0b we=%0b want 0/0", k, grant, mem_we); end
      step();
    end
    n_cmp++; if (perm !== 1'b1) begin n_bad++; $display("FAIL flush_perm: got %0b want 1", perm); end
    mode = 1'b1; step(); step();
    pulse_store(32'h55);
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 4'd0) begin n_bad++; $display("FAIL flush_wptr: got we=%0b addr=%0d want 1/0", mem_we, mem_addr); end
    step();
    ld = 1'b1; step(); ld = 1'b0; step();
    n_cmp++; if (grant !== 1'b1 || data_out !== 32'h55) begin n_bad++; $display("FAIL flush_rptr: got grant=%0b data=%0h want 1/55", grant, data_out); end
    ld = 1'b1; step(); ld = 1'b0; step();
    n_cmp++; if (grant !== 1'b0) begin n_bad++; $display("FAIL flush_count: got %0b want 0", grant); end
    $display("flush checks done");
  endtask

  task automatic test_reset_inflight();
    do_reset(1'b1);
    pulse_store(32'h66); step(); step();
    ld = 1'b1; step(); ld = 1'b0;
    rst = 1'b1;
    step();
    n_cmp++; if (grant !== 1'b0) begin n_bad++; $display("FAIL inflight_grant: got %0b want 0", grant); end
    n_cmp++; if (data_out !== 32'd0) begin n_bad++; $display("FAIL inflight_data: got %0h want 0", data_out); end
    n_cmp++; if (perm !== 1'b1 || mem_we !== 1'b0 || hack !== 1'b0) begin n_bad++; $display("FAIL inflight_outs: got perm=%0b we=%0b ack=%0b want 1/0/0", perm, mem_we, hack); end
    n_cmp++; if (mem_addr !== 4'd0 || mem_wdata !== 32'd0 || hdata !== 32'd0) begin n_bad++; $display("FAIL inflight_buses: got addr=%0d wd=%0h hd=%0h want 0", mem_addr, mem_wdata, hdata); end
    rst = 1'b0;
    step();
    n_cmp++; if (grant !== 1'b0) begin n_bad++; $display("FAIL inflight_late_grant: got %0b want 0", grant); end
    $display("reset during read done");
  endtask

  initial begin
    test_reset();
    test_trace_delay();
    test_host_dump();
    test_stream_full_empty();
    test_contention();
    test_flush();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
